// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port synchronous SRAM (active-low select, one-cycle
// registered read data).
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   CMD_*                 burst command: start address, length-1, direction (valid/ready)
//   WD_*                  write data stream into the SRAM (valid/ready)
//   RD_*                  read data stream out of the SRAM (valid/ready, RD_LAST on final word)
//   DONE                  one-cycle pulse after a burst completes
//   MEM_CSN/WEN/A/DI      SRAM control, address and write data (combinational from state)
//   MEM_DOUT              SRAM read data, sampled one edge after the issue edge
module sram_burst_master #(
  parameter int unsigned BW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WRITE,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [LW-1:0] CMD_LEN,
  input  logic          WD_VALID,
  output logic          WD_READY,
  input  logic [BW-1:0] WD_DATA,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [BW-1:0] RD_DATA,
  output logic          RD_LAST,
  output logic          DONE,
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_A,
  output logic [BW-1:0] MEM_DI,
  input  logic [BW-1:0] MEM_DOUT
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW:0]   RemOne  = {{LW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW:0]   rem_q, rem_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          done_q, done_d;

  // 2-entry read FIFO; each entry carries its last-word tag
  logic [BW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          wptr_q, rptr_q;
  logic [1:0]    count_q;

  logic       cmd_fire, wd_fire, issue, push, pop;
  logic [1:0] credit;

  assign CMD_READY = (state_q == StIdle) && !RST;
  assign WD_READY  = (state_q == StWrite) && !RST;
  assign RD_VALID  = (count_q != 2'd0);
  assign RD_DATA   = fifo_data_q[rptr_q];
  assign RD_LAST   = RD_VALID && fifo_last_q[rptr_q];
  assign DONE      = done_q;

  assign cmd_fire = CMD_VALID && CMD_READY;
  assign wd_fire  = (state_q == StWrite) && WD_VALID && !RST;
  assign pop      = RD_VALID && RD_READY;
  assign push     = inflight_q;

  // Occupancy the FIFO will have after this edge. Crediting the pop in the same
  // cycle keeps one word per cycle flowing while still never exceeding 2 entries.
  assign credit = count_q - {1'b0, pop} + {1'b0, inflight_q};
  assign issue  = (state_q == StRead) && (rem_q != '0) && (credit < 2'd2) && !RST;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == RemOne);
    done_d          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          addr_d  = CMD_ADDR;
          rem_d   = {1'b0, CMD_LEN} + RemOne;
          state_d = CMD_WRITE ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (wd_fire) begin
          addr_d = addr_q + AddrOne;
          rem_d  = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        if (issue) begin
          addr_d = addr_q + AddrOne;
          rem_d  = rem_q - RemOne;
          if (rem_q == RemOne) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && RD_LAST) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    MEM_CSN = 1'b1;
    MEM_WEN = 1'b1;
    MEM_A   = '0;
    MEM_DI  = '0;
    if (wd_fire) begin
      MEM_CSN = 1'b0;
      MEM_WEN = 1'b0;
      MEM_A   = addr_q;
      MEM_DI  = WD_DATA;
    end else if (issue) begin
      MEM_CSN = 1'b0;
      MEM_A   = addr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      fifo_last_q     <= '0;
      wptr_q          <= 1'b0;
      rptr_q          <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      if (push) begin
        fifo_data_q[wptr_q] <= MEM_DOUT;
        fifo_last_q[wptr_q] <= inflight_last_q;
        wptr_q              <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
